alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
- Upstream issue/writeback stage for the 2-bit-opcode ALU (add/mul/div).
- Accepts one command at a time over a valid/ready handshake and reads two source operands from a small internal register file.
- Drives the ALU operand/opcode/carry-in lines, then samples the ALU result and flags one cycle later.
- Writes the result back to a destination register and latches the flags into a status register.

Parameters:
- WIDTH, 3, MSB index of datapath; data words are WIDTH+1 bits.
- NREGS, 4, number of registers; addresses are 2 bits, fixed.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  00 add, 01 mul, 10 div, 11 reserved.
- cmd_ra  in  2  source A register index.
- cmd_rb  in  2  source B register index.
- cmd_rd  in  2  destination register index.
- cmd_ci  in  1  carry-in for add.
- wr_en  in  1  external register load strobe.
- wr_addr  in  2  external load address.
- wr_data  in  WIDTH+1  external load data.
- rd_addr  in  2  debug readback address.
- rd_data  out  WIDTH+1  combinational readback of regfile[rd_addr].
- alu_a, alu_b  out  WIDTH+1  ALU operands.
- alu_op  out  2  ALU opcode.
- alu_ci  out  1  ALU carry-in.
- alu_out  in  WIDTH+1  ALU result.
- alu_neg, alu_zero, alu_carry, alu_ovf  in  1 each  ALU flags.
- flags  out  4  status register {N,Z,C,V}.
- done  out  1  one-cycle pulse: successful writeback.
- err  out  1  one-cycle pulse: command rejected.

Behaviour:
- Reset: all registers 0; flags=0; done=0; err=0; state IDLE; cmd_ready=1; alu_a=alu_b=0; alu_op=00; alu_ci=0.
- FSM states: IDLE, EXEC, WB.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready:
  - Latch op, rd, ci, regfile[ra], regfile[rb] into operand registers.
  - Reject instead, with no state change other than an err pulse next cycle, if op==11, or if op==10 and regfile[rb]==0.
  - A rejected command leaves the FSM in IDLE and leaves regs and flags unchanged.
- EXEC: cmd_ready=0. alu_a/alu_b/alu_op/alu_ci are driven from the latched operand registers and held stable for the whole cycle. Go to WB.
- WB: cmd_ready=0.
  - At the clock edge, write alu_out into regfile[rd] and flags<={alu_neg,alu_zero,alu_carry,alu_ovf}.
  - done=1 in the following cycle; return to IDLE.
- Latency: command accepted at edge T, result and flags visible at T+2, done high during cycle T+2..T+3. Throughput: one command per 3 cycles.
- Outside EXEC and WB, alu_* outputs hold their last values (no glitching required, ALU is combinational).
- Width: no extension or truncation in this block; alu_out is stored as-is (WIDTH+1 bits).
- External wr_en:
  - Accepted in any state.
  - If it targets rd in the same cycle as the WB write, the WB write wins.
  - A write to ra or rb after latch does not affect the in-flight command.
  - wr_en in the same cycle as a command accept: operand read sees pre-write values.
- rd_data reflects writes from the cycle after the write edge.
- rst asserted in any state, including mid-EXEC or WB: no writeback occurs, and all state returns to reset values next cycle.

Decomposition:
- Package alu_pkg:
  - opcode constants OP_ADD=2'b00, OP_MUL=2'b01, OP_DIV=2'b10, OP_RSV=2'b11;
  - FSM state enum {IDLE,EXEC,WB};
  - flag bit indices FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0.
- Sub-module alu_regfile:
  - NREGS x (WIDTH+1);
  - 2 combinational read ports for operands plus 1 for debug readback;
  - 2 write ports with a fixed WB-over-external priority;
  - synchronous reset to 0.

Test Plan:
- Load r0=5, r1=3 via wr_en; ADD rd=r2, ra=r0, rb=r1, ci=0 -> alu_a=5, alu_b=3, alu_op=00 in EXEC; r2=8 at T+2; flags from ALU (Z=0,C=0); done one pulse.
- Load r0=9, r1=8; ADD ci=0 -> ALU returns 1 with carry; r2=1, flags C=1; cmd_ready low for exactly 2 cycles after accept.
- r0=3, r1=5, MUL rd=r3 -> r3=15, Z=0; then DIV r3/r1 -> r3=3.
- DIV with rb=0 -> err pulse, no done, all regs and flags unchanged, cmd_ready stays 1. Same response for op=11 with any operands.
- During WB of an ADD to r2, wr_en to r2 with 4'hF -> r2 holds the ALU result. wr_en to r0 during EXEC -> current result uses the old r0.
- Assert rst during EXEC of a MUL -> no done, dest reg 0, flags 0, cmd_ready 1 in the cycle after rst deasserts.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU operand sequencer:
// opcodes, FSM states and status-flag bit positions.
package alu_pkg;

    localparam int REG_AW = 2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two operand read ports, one debug read port,
// and two write ports where the writeback port wins over the external port.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int NREGS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wb_en,
    input  logic [REG_AW-1:0] i_wb_addr,
    input  logic [WIDTH:0]    i_wb_data,
    input  logic              i_ext_en,
    input  logic [REG_AW-1:0] i_ext_addr,
    input  logic [WIDTH:0]    i_ext_data,
    input  logic [REG_AW-1:0] i_ra_addr,
    output logic [WIDTH:0]    o_ra_data,
    input  logic [REG_AW-1:0] i_rb_addr,
    output logic [WIDTH:0]    o_rb_data,
    input  logic [REG_AW-1:0] i_dbg_addr,
    output logic [WIDTH:0]    o_dbg_data
);

    logic [WIDTH:0] r_regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the array is tiny and architecturally visible after reset, so every entry is cleared.
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (i_wb_en && i_wb_addr == REG_AW'(i))
                    r_regs[i] <= i_wb_data;
                else if (i_ext_en && i_ext_addr == REG_AW'(i))
                    r_regs[i] <= i_ext_data;
            end
        end
    end

    assign o_ra_data  = r_regs[i_ra_addr];
    assign o_rb_data  = r_regs[i_rb_addr];
    assign o_dbg_data = r_regs[i_dbg_addr];

endmodule

// File: rtl/alu_operand_sequencer.sv
// Issue/writeback stage for the 2-bit-opcode ALU: reads operands, drives the ALU,
// then writes the result and flags back one cycle later.
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int NREGS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_ra,
    input  logic [REG_AW-1:0] cmd_rb,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic              cmd_ci,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [WIDTH:0]    wr_data,
    input  logic [REG_AW-1:0] rd_addr,
    output logic [WIDTH:0]    rd_data,
    output logic [WIDTH:0]    alu_a,
    output logic [WIDTH:0]    alu_b,
    output logic [1:0]        alu_op,
    output logic              alu_ci,
    input  logic [WIDTH:0]    alu_out,
    input  logic              alu_neg,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_ovf,
    output logic [3:0]        flags,
    output logic              done,
    output logic              err
);

    state_t            r_state;
    logic              r_cmd_ready;
    logic [WIDTH:0]    r_alu_a;
    logic [WIDTH:0]    r_alu_b;
    logic [1:0]        r_alu_op;
    logic              r_alu_ci;
    logic [REG_AW-1:0] r_rd;
    logic [3:0]        r_flags;
    logic              r_done;
    logic              r_err;

    logic [WIDTH:0]    w_ra_data;
    logic [WIDTH:0]    w_rb_data;
    logic              w_accept;
    logic              w_reject;
    logic              w_wb_en;

    assign w_accept = cmd_valid && r_cmd_ready;
    assign w_reject = (cmd_op == OP_RSV) || (cmd_op == OP_DIV && w_rb_data == '0);
    assign w_wb_en  = (r_state == WB);

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_wb_en    (w_wb_en),
        .i_wb_addr  (r_rd),
        .i_wb_data  (alu_out),
        .i_ext_en   (wr_en),
        .i_ext_addr (wr_addr),
        .i_ext_data (wr_data),
        .i_ra_addr  (cmd_ra),
        .o_ra_data  (w_ra_data),
        .i_rb_addr  (cmd_rb),
        .o_rb_data  (w_rb_data),
        .i_dbg_addr (rd_addr),
        .o_dbg_data (rd_data)
    );

    // The ALU operand lines are themselves the operand latches, so they
    // hold their last values whenever no command is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b1;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= OP_ADD;
            r_alu_ci    <= 1'b0;
            r_rd        <= '0;
            r_flags     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_reject) begin
                            r_err <= 1'b1;
                        end else begin
                            r_alu_a     <= w_ra_data;
                            r_alu_b     <= w_rb_data;
                            r_alu_op    <= cmd_op;
                            r_alu_ci    <= cmd_ci;
                            r_rd        <= cmd_rd;
                            r_cmd_ready <= 1'b0;
                            r_state     <= EXEC;
                        end
                    end
                end
                EXEC: r_state <= WB;
                WB: begin
                    r_flags[FLG_N] <= alu_neg;
                    r_flags[FLG_Z] <= alu_zero;
                    r_flags[FLG_C] <= alu_carry;
                    r_flags[FLG_V] <= alu_ovf;
                    r_done         <= 1'b1;
                    r_cmd_ready    <= 1'b1;
                    r_state        <= IDLE;
                end
                default: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign alu_ci    = r_alu_ci;
    assign flags     = r_flags;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer: an ALU stub answers the DUT, a
// register/flag model predicts each response, and a monitor checks done/err pulses.
module tb_alu_operand_sequencer;
    import alu_pkg::*;

    localparam int WIDTH = 3;
    localparam int W     = WIDTH + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic [1:0]     cmd_ra, cmd_rb, cmd_rd;
    logic           cmd_ci;
    logic           wr_en;
    logic [1:0]     wr_addr;
    logic [W-1:0]   wr_data;
    logic [1:0]     rd_addr;
    logic [W-1:0]   rd_data;
    logic [W-1:0]   alu_a, alu_b, alu_out;
    logic [1:0]     alu_op;
    logic           alu_ci;
    logic           alu_neg, alu_zero, alu_carry, alu_ovf;
    logic [3:0]     flags;
    logic           done, err;

    always #5 clk = ~clk;

    alu_operand_sequencer #(.WIDTH(WIDTH), .NREGS(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd), .cmd_ci(cmd_ci),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_ci(alu_ci),
        .alu_out(alu_out), .alu_neg(alu_neg), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .alu_ovf(alu_ovf),
        .flags(flags), .done(done), .err(err)
    );

    typedef struct packed {
        logic [3:0]   flg;
        logic [W-1:0] val;
    } alu_res_t;

    function automatic alu_res_t alu_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] op, input logic ci);
        alu_res_t     r;
        logic [W:0]   s;
        logic [2*W-1:0] p;
        r = '0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
                r.val        = s[W-1:0];
                r.flg[FLG_C] = s[W];
                r.flg[FLG_V] = (a[W-1] == b[W-1]) && (r.val[W-1] != a[W-1]);
            end
            OP_MUL: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                r.val        = p[W-1:0];
                r.flg[FLG_C] = |p[2*W-1:W];
                r.flg[FLG_V] = |p[2*W-1:W];
            end
            OP_DIV:  r.val = (b == '0) ? '0 : a / b;
            default: r.val = '0;
        endcase
        r.flg[FLG_N] = r.val[W-1];
        r.flg[FLG_Z] = (r.val == '0);
        return r;
    endfunction

    alu_res_t alu_res;
    assign alu_res = alu_calc(alu_a, alu_b, alu_op, alu_ci);
    assign alu_out = alu_res.val;
    assign {alu_neg, alu_zero, alu_carry, alu_ovf} = alu_res.flg;

    typedef struct {
        logic         is_err;
        logic [1:0]   rd;
        logic [W-1:0] val;
        logic [3:0]   flg;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] m_regs [4];
    logic [3:0]   m_flags;
    int           n_checks = 0;
    int           n_errors = 0;

    logic         mon_sel = 1'b0;
    logic [1:0]   mon_addr = '0;
    logic [1:0]   stim_addr = '0;
    assign rd_addr = mon_sel ? mon_addr : stim_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every done/err pulse must match the oldest outstanding prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1 || err === 1'b1) begin
                check("resp_expected", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("resp_kind", {done, err}, e.is_err ? 2'b01 : 2'b10);
                    check("resp_flags", flags, e.flg);
                    if (!e.is_err) begin
                        mon_addr = e.rd;
                        mon_sel  = 1'b1;
                        #1;
                        check("wb_value", rd_data, e.val);
                        mon_sel  = 1'b0;
                    end
                end
            end
        end
    end

    task automatic load(input logic [1:0] a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); @(negedge clk);
        wr_en = 1'b0;
        m_regs[a] = d;
    endtask

    task automatic ext_drive(input int ph, input int want, input logic [1:0] wa, input logic [W-1:0] wd);
        if (ph == want) begin
            wr_en = 1'b1; wr_addr = wa; wr_data = wd;
        end
    endtask

    task automatic ext_apply();
        if (wr_en) m_regs[wr_addr] = wr_data;
        wr_en = 1'b0;
    endtask

    // ph selects when an external write rides along: 1 accept, 2 EXEC, 3 WB.
    task automatic issue(input logic [1:0] op, input logic [1:0] ra, input logic [1:0] rb,
                         input logic [1:0] rd, input logic ci, input int ph,
                         input logic [1:0] wa, input logic [W-1:0] wd);
        exp_t         e;
        alu_res_t     r;
        logic         rej;
        logic [W-1:0] av, bv;
        check("ready_idle", cmd_ready, 1);
        av  = m_regs[ra];
        bv  = m_regs[rb];
        rej = (op == OP_RSV) || (op == OP_DIV && bv == '0);
        r   = alu_calc(av, bv, op, ci);
        e.is_err = rej; e.rd = rd; e.val = r.val;
        e.flg    = rej ? m_flags : r.flg;
        sb_q.push_back(e);
        cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_ci = ci;
        ext_drive(ph, 1, wa, wd);
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        ext_apply();
        if (rej) begin
            check("ready_after_reject", cmd_ready, 1);
            return;
        end
        check("exec_ready", cmd_ready, 0);
        check("exec_alu_a", alu_a, av);
        check("exec_alu_b", alu_b, bv);
        check("exec_alu_op", alu_op, op);
        check("exec_alu_ci", alu_ci, ci);
        ext_drive(ph, 2, wa, wd);
        @(posedge clk); @(negedge clk);
        ext_apply();
        check("wb_ready", cmd_ready, 0);
        ext_drive(ph, 3, wa, wd);
        @(posedge clk); @(negedge clk);
        ext_apply();
        m_regs[rd] = r.val;
        m_flags    = r.flg;
        check("ready_back", cmd_ready, 1);
    endtask

    task automatic sweep();
        @(negedge clk);
        #2;
        for (int a = 0; a < 4; a++) begin
            stim_addr = 2'(a);
            #1;
            check("reg_sweep", rd_data, m_regs[a]);
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rd = '0;
        cmd_ci = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_flags = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", cmd_ready, 1);
        check("rst_flags", flags, 0);
        check("rst_done_err", {done, err}, 0);
        check("rst_alu", {alu_a, alu_b, alu_op, alu_ci}, 0);
        sweep();

        load(0, 5); load(1, 3);
        issue(OP_ADD, 0, 1, 2, 0, 0, 0, 0);
        load(0, 9); load(1, 8);
        issue(OP_ADD, 0, 1, 2, 0, 0, 0, 0);
        load(0, 3); load(1, 5);
        issue(OP_MUL, 0, 1, 3, 0, 0, 0, 0);
        issue(OP_DIV, 3, 1, 3, 0, 0, 0, 0);
        sweep();

        load(1, 0);
        issue(OP_DIV, 0, 1, 2, 0, 0, 0, 0);
        issue(OP_RSV, 2, 3, 0, 1, 0, 0, 0);
        sweep();

        load(1, 6);
        issue(OP_ADD, 0, 1, 2, 1, 3, 2, 4'hF);
        issue(OP_ADD, 0, 1, 3, 0, 2, 0, 4'h7);
        issue(OP_MUL, 0, 1, 2, 0, 1, 0, 4'h2);
        sweep();

        // Reset in the middle of an EXEC cycle must cancel the writeback.
        load(0, 7); load(1, 2);
        cmd_valid = 1'b1; cmd_op = OP_MUL; cmd_ra = 0; cmd_rb = 1; cmd_rd = 3; cmd_ci = 0;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_flags = '0;
        check("midrst_ready", cmd_ready, 1);
        check("midrst_flags", flags, 0);
        check("midrst_alu_a", alu_a, 0);
        @(posedge clk); @(negedge clk);
        check("midrst_no_done", done, 0);
        sweep();

        for (int n = 0; n < 80; n++) begin
            logic [W-1:0] d;
            if ($urandom_range(0, 3) == 0) begin
                d = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
                load(2'($urandom), d);
            end
            d = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            issue(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), 2'($urandom), d);
        end
        sweep();

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
